// File: rtl/ysyx22041405_mcycle_ctrl.sv
// ysyx22041405_mcycle_ctrl: multi-cycle sequencer for the ysyx22041405 core.
// Owns the shared memory port (fetch + load/store), pc/rf strobes, instret
// and the halt/timeout stop.
// Ports: clk/rst (async, active-low); if_addr/ls_addr request addresses;
//   is_load/is_store/rd_write/halt_req decode inputs; mem_req_* request
//   channel (valid/ready); mem_resp_* response; inst/ld_data latches;
//   pc_en/rf_we strobes; instret count; halted/err stop flags; stage debug.

module ysyx22041405_mcycle_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] if_addr,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             rd_write,
  input  logic             halt_req,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_we,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_data,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] ld_data,
  output logic             pc_en,
  output logic             rf_we,
  output logic [31:0]      instret,
  output logic             halted,
  output logic             err,
  output logic [3:0]       stage
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    IF_REQ   = 4'd1,
    IF_WAIT  = 4'd2,
    ID       = 4'd3,
    EX       = 4'd4,
    MEM_REQ  = 4'd5,
    MEM_WAIT = 4'd6,
    WB       = 4'd7,
    HALT     = 4'd8
  } state_t;

  localparam logic [7:0] WD_MAX = 8'(TIMEOUT);

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       wd_q;
  logic             st_q;
  logic [WIDTH-1:0] inst_q;
  logic [WIDTH-1:0] ld_q;
  logic [31:0]      instret_q;
  logic             err_q;
  logic             wait_st;
  logic             expire;

  assign wait_st = (state_q == IF_WAIT) ||
                   (state_q == MEM_WAIT);

  // The cycle that would bring the counter to TIMEOUT
  // ends the wait, unless a response shows up in it.
  assign expire = wait_st && !mem_resp_valid &&
                  ((wd_q + 8'd1) == WD_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = IF_REQ;
      IF_REQ: begin
        if (mem_req_ready) state_d = IF_WAIT;
      end
      IF_WAIT: begin
        if (mem_resp_valid) state_d = ID;
        else if (expire)    state_d = HALT;
      end
      ID: begin
        state_d = halt_req ? HALT : EX;
      end
      EX: begin
        state_d = (is_load || is_store) ? MEM_REQ : WB;
      end
      MEM_REQ: begin
        if (mem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_resp_valid) state_d = WB;
        else if (expire)    state_d = HALT;
      end
      WB:      state_d = IF_REQ;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Wait states are only ever entered from non-wait
  // states, so clearing outside them clears on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= 8'd0;
    end else if (wait_st) begin
      wd_q <= wd_q + 8'd1;
    end else begin
      wd_q <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= 1'b0;
    end else if (state_q == EX) begin
      st_q <= is_store;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q <= '0;
    end else if (state_q == IF_WAIT && mem_resp_valid) begin
      inst_q <= mem_resp_data;
    end
  end

  // A store response carries no data; ld_data holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_q <= '0;
    end else if (state_q == MEM_WAIT && mem_resp_valid &&
                 !st_q) begin
      ld_q <= mem_resp_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= 32'd0;
    end else if (state_q == WB) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (expire) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    pc_en         = 1'b0;
    rf_we         = 1'b0;
    halted        = 1'b0;
    unique case (state_q)
      IF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = if_addr;
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = st_q;
        mem_req_addr  = ls_addr;
      end
      WB: begin
        pc_en = 1'b1;
        rf_we = rd_write & ~st_q;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign inst    = inst_q;
  assign ld_data = ld_q;
  assign instret = instret_q;
  assign err     = err_q;
  assign stage   = state_q;

  a_rf_with_pc: assert property (
    @(posedge clk) disable iff (!rst)
    rf_we |-> pc_en);

  a_no_req_in_wb: assert property (
    @(posedge clk) disable iff (!rst)
    pc_en |-> !mem_req_valid);

endmodule

// File: tb/tb_ysyx22041405_mcycle_ctrl.sv
// tb_ysyx22041405_mcycle_ctrl: directed + random bench for the sequencer.
// A per-instruction latency/result model drives and checks the DUT.

module tb_ysyx22041405_mcycle_ctrl;

  localparam int W   = 32;
  localparam int TO  = 4;
  localparam int ALU = 0;
  localparam int LD  = 1;
  localparam int ST  = 2;
  localparam int EB  = 3;

  typedef struct {
    int          kind;
    bit          rd;
    logic [31:0] iw;
    logic [31:0] ldv;
    logic [31:0] ls;
    int          rf;
    int          pf;
    int          rm;
    int          pm;
  } ins_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] if_addr;
  logic [W-1:0] ls_addr;
  logic         is_load;
  logic         is_store;
  logic         rd_write;
  logic         halt_req;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_we;
  logic [W-1:0] mem_req_addr;
  logic         mem_resp_valid;
  logic [W-1:0] mem_resp_data;
  logic [W-1:0] inst;
  logic [W-1:0] ld_data;
  logic         pc_en;
  logic         rf_we;
  logic [31:0]  instret;
  logic         halted;
  logic         err;
  logic [3:0]   stage;

  ysyx22041405_mcycle_ctrl #(
    .WIDTH(W),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_addr(if_addr),
    .ls_addr(ls_addr),
    .is_load(is_load),
    .is_store(is_store),
    .rd_write(rd_write),
    .halt_req(halt_req),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .inst(inst),
    .ld_data(ld_data),
    .pc_en(pc_en),
    .rf_we(rf_we),
    .instret(instret),
    .halted(halted),
    .err(err),
    .stage(stage)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  int          checks;
  int          failures;
  ins_t        prog[64];
  int          plen;
  ins_t        cur;
  int          idx;
  int          cyc;
  int          last;
  int          retired;
  bit          fetched;
  bit          pend;
  bit          noise;
  int          rcnt;
  int          pcnt;
  logic [31:0] pdata;
  logic [31:0] pc;
  logic [31:0] exp_ld;
  logic [31:0] ibase;
  int          pcc[8];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input int kind,
                              input bit rd,
                              input logic [31:0] iw,
                              input logic [31:0] ldv,
                              input logic [31:0] ls,
                              input int rf,
                              input int pf,
                              input int rm,
                              input int pm);
    ins_t t;
    t.kind = kind;
    t.rd   = rd;
    t.iw   = iw;
    t.ldv  = ldv;
    t.ls   = ls;
    t.rf   = rf;
    t.pf   = pf;
    t.rm   = rm;
    t.pm   = pm;
    return t;
  endfunction

  // Cycles from IF_REQ entry to WB, inclusive.
  function automatic int lat_of(input ins_t t);
    int n;
    n = 5 + t.rf + t.pf;
    if (t.kind == LD || t.kind == ST) n = n + 2 + t.rm + t.pm;
    return n;
  endfunction

  task automatic drive();
    if_addr  = pc;
    ls_addr  = cur.ls;
    is_load  = (cur.kind == LD);
    is_store = (cur.kind == ST);
    halt_req = (cur.kind == EB);
    rd_write = cur.rd;
  endtask

  task automatic load_cur();
    if (idx < plen) cur = prog[idx];
    else cur = mk(ALU, 1'b1, 32'h13, 32'h0, 32'h0, 0, 0, 0, 0);
    fetched = 1'b0;
    rcnt    = 0;
    drive();
  endtask

  // One model step, called at every falling edge.
  task automatic step();
    int lim;
    cyc++;
    if (pend) begin
      if (pcnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = pdata;
        pend           = 1'b0;
      end else begin
        pcnt--;
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
      end
    end else begin
      mem_resp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_resp_data  = $urandom;
    end
    if (mem_req_valid) begin
      if (!fetched) begin
        chk("if_addr", 64'(mem_req_addr), 64'(pc));
        chk("if_we", 64'(mem_req_we), 64'(0));
        lim = cur.rf;
      end else begin
        chk("ls_addr", 64'(mem_req_addr), 64'(cur.ls));
        chk("ls_we", 64'(mem_req_we), 64'(cur.kind == ST));
        lim = cur.rm;
      end
      if (rcnt < lim) begin
        mem_req_ready = 1'b0;
        rcnt++;
      end else begin
        mem_req_ready = 1'b1;
        rcnt = 0;
        pend = 1'b1;
        if (!fetched) begin
          pcnt    = cur.pf;
          pdata   = cur.iw;
          fetched = 1'b1;
        end else begin
          pcnt = cur.pm;
          if (cur.kind == LD) begin
            pdata  = cur.ldv;
            exp_ld = cur.ldv;
          end else begin
            pdata = $urandom;
          end
        end
      end
    end else begin
      mem_req_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (pc_en) begin
      chk("rf_we", 64'(rf_we), 64'(cur.rd && cur.kind != ST));
      chk("inst", 64'(inst), 64'(cur.iw));
      chk("ld_data", 64'(ld_data), 64'(exp_ld));
      chk("instret_wb", 64'(instret), 64'(ibase + 32'(retired)));
      chk("latency", 64'(cyc - last), 64'(lat_of(cur)));
      if (retired < 8) pcc[retired] = cyc;
      retired++;
      last = cyc;
      pc   = pc + 32'd4;
      idx++;
      load_cur();
    end else begin
      chk("rf_we_idle", 64'(rf_we), 64'(0));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_stage"}, 64'(stage), 64'(0));
    chk({tag, "_valid"}, 64'(mem_req_valid), 64'(0));
    chk({tag, "_we"}, 64'(mem_req_we), 64'(0));
    chk({tag, "_pc_en"}, 64'(pc_en), 64'(0));
    chk({tag, "_rf_we"}, 64'(rf_we), 64'(0));
    chk({tag, "_halted"}, 64'(halted), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_inst"}, 64'(inst), 64'(0));
    chk({tag, "_ld"}, 64'(ld_data), 64'(0));
    chk({tag, "_instret"}, 64'(instret), 64'(0));
  endtask

  task automatic start();
    rst     = 1'b0;
    idx     = 0;
    cyc     = 0;
    last    = 1;
    retired = 0;
    pend    = 1'b0;
    pcnt    = 0;
    pc      = 32'h8000_0000;
    exp_ld  = '0;
    ibase   = '0;
    for (int i = 0; i < 8; i++) pcc[i] = 0;
    load_cur();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (2) @(negedge clk);
    reset_chk("rst");
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_ret(input int n, input int lim);
    int k;
    k = 0;
    while (retired < n && k < lim) begin
      cycles(1);
      k++;
    end
    chk("wait_ret", 64'(retired), 64'(n));
  endtask

  initial begin
    int cnt;
    int k;
    checks   = 0;
    failures = 0;
    noise    = 1'b0;
    plen     = 0;
    rst      = 1'b0;
    cur      = mk(ALU, 1'b1, 32'h13, 32'h0, 32'h0, 0, 0, 0, 0);
    pc       = 32'h8000_0000;
    drive();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    plen    = 5;
    prog[0] = mk(ALU, 1'b1, 32'h00100093, 0, 0, 0, 0, 0, 0);
    prog[1] = mk(ALU, 1'b1, 32'h00200113, 0, 0, 0, 0, 0, 0);
    prog[2] = mk(ALU, 1'b1, 32'h00300193, 0, 0, 0, 0, 0, 0);
    prog[3] = mk(LD, 1'b1, 32'h00052203, 32'hDEADBEEF,
                 32'h8000_0100, 0, 0, 0, 0);
    prog[4] = mk(ST, 1'b1, 32'h00452023, 32'h0,
                 32'h8000_0200, 0, 0, 4, 0);
    start();
    wait_ret(5, 100);
    chk("pc_en_1", 64'(pcc[0]), 64'(6));
    chk("pc_en_2", 64'(pcc[1]), 64'(11));
    chk("pc_en_3", 64'(pcc[2]), 64'(16));
    chk("pc_en_ld", 64'(pcc[3]), 64'(23));
    chk("pc_en_st", 64'(pcc[4]), 64'(34));
    cycles(1);
    chk("instret_5", 64'(instret), 64'(5));
    chk("ld_hold", 64'(ld_data), 64'(32'hDEADBEEF));

    plen    = 1;
    prog[0] = mk(ALU, 1'b1, 32'h13, 0, 0, 0, 100, 0, 0);
    start();
    cycles(6);
    chk("to_wait", 64'(stage), 64'(2));
    cycles(1);
    chk("to_stage", 64'(stage), 64'(8));
    chk("to_err", 64'(err), 64'(1));
    chk("to_halted", 64'(halted), 64'(1));
    chk("to_valid", 64'(mem_req_valid), 64'(0));

    plen    = 1;
    prog[0] = mk(ALU, 1'b1, 32'h00500293, 0, 0, 0, 3, 0, 0);
    start();
    cycles(6);
    chk("win_wait", 64'(stage), 64'(2));
    cycles(1);
    chk("win_stage", 64'(stage), 64'(3));
    chk("win_err", 64'(err), 64'(0));
    wait_ret(1, 20);

    plen    = 3;
    prog[0] = mk(ALU, 1'b1, 32'h00600313, 0, 0, 0, 0, 0, 0);
    prog[1] = mk(ALU, 1'b0, 32'h00700393, 0, 0, 1, 1, 0, 0);
    prog[2] = mk(EB, 1'b0, 32'h00100073, 0, 0, 0, 0, 0, 0);
    start();
    wait_ret(2, 60);
    cycles(8);
    chk("eb_stage", 64'(stage), 64'(8));
    chk("eb_halted", 64'(halted), 64'(1));
    chk("eb_err", 64'(err), 64'(0));
    chk("eb_instret", 64'(instret), 64'(2));
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      cnt += int'(mem_req_valid) + int'(pc_en);
    end
    chk("eb_quiet", 64'(cnt), 64'(0));

    plen    = 1;
    prog[0] = mk(ALU, 1'b1, 32'h13, 0, 0, 0, 50, 0, 0);
    start();
    cycles(3);
    chk("mid_wait", 64'(stage), 64'(2));
    #2 rst = 1'b0;
    #1 reset_chk("mid");

    plen    = 1;
    prog[0] = mk(ALU, 1'b1, 32'h00800413, 0, 0, 0, 2, 0, 0);
    start();
    cycles(3);
    force dut.instret_q = 32'hFFFF_FFFF;
    ibase = 32'hFFFF_FFFF;
    cycles(1);
    release dut.instret_q;
    chk("preload", 64'(instret), 64'(32'hFFFF_FFFF));
    wait_ret(1, 20);
    cycles(1);
    chk("wrap", 64'(instret), 64'(0));

    noise = 1'b1;
    plen  = 40;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 2));
      prog[i] = mk(k, 1'($urandom_range(0, 1)), $urandom,
                   $urandom, $urandom,
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
    end
    start();
    wait_ret(40, 1000);
    cycles(1);
    chk("rand_instret", 64'(instret), 64'(40));
    chk("rand_err", 64'(err), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
